text_overlay_ctrl: RTL and testbench

- Owns the character buffer (text RAM) and sequences the ascii font engine. Each display cycle it converts the engine's char_x/char_y into a buffer read. It then selects the matching bit of the engine's ascii_char vector to form one foreground pixel.
- Host character writes and a full-screen clear sweep share the single buffer port with the display. The display always has priority, so the other two only get the port during blanking.
- Sits between the VGA timing/font engine and the pixel mux.

---
 rtl/text_pkg.sv | 23 ++
 rtl/text_ram.sv | 17 +
 rtl/text_overlay_ctrl.sv | 123 ++++++++++++
 tb/tb_text_overlay_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared constants, types and address helper for the text overlay controller.
package text_pkg;
  localparam int COLS   = 106;
  localparam int ROWS   = 60;
  localparam int ADDR_W = 13;
  localparam int DEPTH  = COLS * ROWS;

  localparam logic [7:0] CLR_CODE = 8'h20;
  localparam logic [7:0] COLS_B   = 8'(COLS);
  localparam logic [7:0] ROWS_B   = 8'(ROWS);

  typedef enum logic {IDLE, CLEAR} clr_state_t;
  typedef logic [ADDR_W-1:0] text_addr_t;

  localparam text_addr_t LAST_ADDR = text_addr_t'(DEPTH - 1);

  // Row-major cell index; widened to 16 bits so row*COLS cannot wrap before the cast.
  function automatic text_addr_t cell_addr(input logic [7:0] row, input logic [7:0] col);
    logic [15:0] a;
    a = 16'(row) * 16'(COLS) + 16'(col);
    return text_addr_t'(a);
  endfunction
endpackage

// File: rtl/text_ram.sv
// Single-port character buffer: synchronous read, one-cycle latency, no reset.
module text_ram
  import text_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  text_addr_t addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/text_overlay_ctrl.sv
// Character buffer owner: display reads, host writes and clear sweep share one port.
// Optional blinking cursor cell enabled by defining TEXT_CURSOR_EN.
//   state | meaning
//   IDLE  | host owns the port during blank
//   CLEAR | sweep writes CLR_CODE during blank, stalls during active video
module text_overlay_ctrl
  import text_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         blank,
  input  logic         vsync,
  input  logic [7:0]   char_x,
  input  logic [7:0]   char_y,
  input  logic [255:0] ascii_char,
  input  logic         host_valid,
  output logic         host_ready,
  input  logic [7:0]   host_col,
  input  logic [7:0]   host_row,
  input  logic [7:0]   host_code,
  input  logic         clear_req,
  output logic         clear_busy,
`ifdef TEXT_CURSOR_EN
  input  logic [7:0]   cursor_col,
  input  logic [7:0]   cursor_row,
`endif
  output logic         fg_pix
);
  clr_state_t state, state_nxt;
  text_addr_t clr_addr;
  text_addr_t ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       inrange_d1;
  logic       invert;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear_req) state_nxt = CLEAR;
      CLEAR:   if (blank && clr_addr == LAST_ADDR) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Display has priority; the sweep and the host only see the port during blank.
  always_comb begin
    host_ready = blank && (state == IDLE);
    clear_busy = (state == CLEAR);
    ram_we     = 1'b0;
    ram_addr   = cell_addr(char_y, char_x);
    ram_wdata  = host_code;
    if (blank) begin
      if (state == CLEAR) begin
        ram_we    = 1'b1;
        ram_addr  = clr_addr;
        ram_wdata = CLR_CODE;
      end else begin
        ram_addr = cell_addr(host_row, host_col);
        ram_we   = host_valid && (host_col < COLS_B) && (host_row < ROWS_B);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_addr <= '0;
    end else if (state == IDLE && clear_req) begin
      clr_addr <= '0;
    end else if (state == CLEAR && blank) begin
      clr_addr <= clr_addr + text_addr_t'(1);
    end
  end

  text_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

`ifdef TEXT_CURSOR_EN
  logic [5:0] frame_cnt;
  logic       vsync_d;
  logic       cursor_d1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
      vsync_d   <= 1'b0;
      cursor_d1 <= 1'b0;
    end else begin
      vsync_d   <= vsync;
      cursor_d1 <= (char_x == cursor_col) && (char_y == cursor_row);
      if (vsync && !vsync_d) frame_cnt <= frame_cnt + 6'd1;
    end
  end

  assign invert = cursor_d1 & frame_cnt[5];
`else
  logic unused_vsync;
  assign unused_vsync = vsync;
  assign invert       = 1'b0;
`endif

  // ascii_char arrives one clock after char_x/char_y, lining up with ram_rdata.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inrange_d1 <= 1'b0;
      fg_pix     <= 1'b0;
    end else begin
      inrange_d1 <= (char_x < COLS_B) && (char_y < ROWS_B) && !blank;
      fg_pix     <= inrange_d1 & (ascii_char[ram_rdata] ^ invert);
    end
  end
endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Self-checking bench for text_overlay_ctrl: cycle-by-cycle pixel model plus directed checks.
module tb_text_overlay_ctrl;
  localparam int COLS  = 106;
  localparam int ROWS  = 60;
  localparam int NCELL = COLS * ROWS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blank = 1'b0;
  logic         vsync = 1'b0;
  logic [7:0]   char_x = 8'd200;
  logic [7:0]   char_y = 8'd0;
  logic [255:0] ascii_char = '0;
  logic         host_valid = 1'b0;
  logic         host_ready;
  logic [7:0]   host_col = 8'd0;
  logic [7:0]   host_row = 8'd0;
  logic [7:0]   host_code = 8'd0;
  logic         clear_req = 1'b0;
  logic         clear_busy;
  logic         fg_pix;

  always #5 clk = ~clk;

  text_overlay_ctrl dut (
    .clk        (clk),
    .reset      (rst_n),
    .blank      (blank),
    .vsync      (vsync),
    .char_x     (char_x),
    .char_y     (char_y),
    .ascii_char (ascii_char),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_col   (host_col),
    .host_row   (host_row),
    .host_code  (host_code),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
`ifdef TEXT_CURSOR_EN
    .cursor_col (8'hFF),
    .cursor_row (8'hFF),
`endif
    .fg_pix     (fg_pix)
  );

  logic [7:0] mem_model [NCELL];
  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Pixel for a cell shown at cycle t = in-range & glyph bit (from the cycle t+1 vector) of stored code.
  logic       s1_inr = 1'b0;
  logic [7:0] s1_code = 8'd0;
  logic       fg_exp = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_inr <= 1'b0;
      fg_exp <= 1'b0;
    end else begin
      fg_exp  <= s1_inr & ascii_char[s1_code];
      s1_inr  <= !blank && (char_x < COLS) && (char_y < ROWS);
      s1_code <= ((char_x < COLS) && (char_y < ROWS)) ? mem_model[char_y * COLS + char_x] : 8'h00;
    end
  end

  always @(negedge clk) begin
    if (rst_n) check("fg_pix_model", {31'd0, fg_pix}, {31'd0, fg_exp});
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] bit_of(input int i);
    logic [255:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic rand_ascii;
    for (int k = 0; k < 8; k++) ascii_char[k*32 +: 32] = $urandom;
  endtask

  task automatic host_write(input int col, input int row, input logic [7:0] code);
    blank = 1'b1;
    host_col = 8'(col);
    host_row = 8'(row);
    host_code = code;
    host_valid = 1'b1;
    #1 check("host_ready_blank", {31'd0, host_ready}, 32'd1);
    tick();
    host_valid = 1'b0;
    if (col < COLS && row < ROWS) mem_model[row * COLS + col] = code;
  endtask

  task automatic disp(input int x, input int y, input logic [255:0] vec, input logic exp,
                      input string name);
    blank = 1'b0;
    char_x = 8'(x);
    char_y = 8'(y);
    tick();
    ascii_char = vec;
    char_x = 8'd200;
    tick();
    check(name, {31'd0, fg_pix}, {31'd0, exp});
  endtask

  task automatic scan_rows(input int r0, input int r1);
    blank = 1'b0;
    for (int r = r0; r <= r1; r++) begin
      for (int c = 0; c < COLS; c++) begin
        char_x = 8'(c);
        char_y = 8'(r);
        rand_ascii();
        tick();
      end
    end
    char_x = 8'd200;
    rand_ascii();
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < NCELL; i++) mem_model[i] = 8'h00;

    repeat (3) tick();
    check("reset_host_ready", {31'd0, host_ready}, 32'd0);
    check("reset_clear_busy", {31'd0, clear_busy}, 32'd0);
    check("reset_fg_pix", {31'd0, fg_pix}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Full clear sweep with stalls, an ignored re-request and a refused host request.
    blank = 1'b1;
    clear_req = 1'b1;
    #1 check("ready_before_clear", {31'd0, host_ready}, 32'd1);
    tick();
    clear_req = 1'b0;
    check("busy_after_req", {31'd0, clear_busy}, 32'd1);
    check("ready_in_clear", {31'd0, host_ready}, 32'd0);
    for (int n = 0; n < NCELL; n++) begin
      if (n % 1500 == 700) begin
        blank = 1'b0;
        repeat (4) begin
          tick();
          check("busy_stalled", {31'd0, clear_busy}, 32'd1);
        end
        blank = 1'b1;
      end
      if (n == 50) clear_req = 1'b1;
      if (n == 3000) begin
        host_col = 8'd5;
        host_row = 8'd5;
        host_code = 8'h7E;
        host_valid = 1'b1;
        #1 check("ready_refused_clear", {31'd0, host_ready}, 32'd0);
      end
      if (n == NCELL - 1) check("busy_before_last", {31'd0, clear_busy}, 32'd1);
      tick();
      clear_req = 1'b0;
      host_valid = 1'b0;
    end
    check("busy_done", {31'd0, clear_busy}, 32'd0);
    check("ready_after_clear", {31'd0, host_ready}, 32'd1);
    for (int i = 0; i < NCELL; i++) mem_model[i] = 8'h20;

    scan_rows(0, ROWS - 1);
    disp(0, 0, bit_of(32), 1'b1, "cleared_first");
    disp(105, 59, bit_of(32), 1'b1, "cleared_last");
    disp(5, 5, bit_of(8'h7E), 1'b0, "no_write_in_clear");

    // Host writes and the display path.
    host_write(2, 1, 8'h41);
    disp(2, 1, bit_of(65), 1'b1, "glyph_A_set");
    disp(2, 1, ~bit_of(65), 1'b0, "glyph_A_clear");

    blank = 1'b0;
    host_col = 8'd3;
    host_row = 8'd1;
    host_code = 8'h42;
    host_valid = 1'b1;
    #1 check("ready_active", {31'd0, host_ready}, 32'd0);
    repeat (3) begin
      tick();
      check("ready_active_hold", {31'd0, host_ready}, 32'd0);
    end
    blank = 1'b1;
    #1 check("ready_first_blank", {31'd0, host_ready}, 32'd1);
    tick();
    host_valid = 1'b0;
    mem_model[1 * COLS + 3] = 8'h42;
    disp(3, 1, bit_of(66), 1'b1, "held_write_B");

    host_write(106, 0, 8'h55);
    disp(0, 1, bit_of(8'h55), 1'b0, "oor_write_dropped");
    disp(0, 1, bit_of(32), 1'b1, "oor_neighbour_kept");
    host_write(105, 59, 8'h7A);
    host_write(0, 0, 8'h30);
    disp(106, 0, ~256'd0, 1'b0, "oor_col_display");
    disp(0, 60, ~256'd0, 1'b0, "oor_row_display");
    disp(105, 59, bit_of(8'h7A), 1'b1, "last_cell_z");
    scan_rows(0, 1);
    scan_rows(59, 59);

    // Reset partway through a sweep, with a host write coinciding with the request.
    host_write(99, 0, 8'h41);
    host_write(100, 0, 8'h41);
    blank = 1'b1;
    clear_req = 1'b1;
    host_col = 8'd94;
    host_row = 8'd1;
    host_code = 8'h42;
    host_valid = 1'b1;
    #1 check("ready_with_clear_req", {31'd0, host_ready}, 32'd1);
    tick();
    clear_req = 1'b0;
    host_valid = 1'b0;
    mem_model[1 * COLS + 94] = 8'h42;
    check("busy_second_sweep", {31'd0, clear_busy}, 32'd1);
    repeat (100) tick();
    rst_n = 1'b0;
    #1 check("busy_in_reset", {31'd0, clear_busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1 check("busy_after_reset", {31'd0, clear_busy}, 32'd0);
    check("ready_after_reset", {31'd0, host_ready}, 32'd1);
    blank = 1'b0;
    #1 check("ready_follows_blank", {31'd0, host_ready}, 32'd0);
    for (int i = 0; i < 100; i++) mem_model[i] = 8'h20;

    disp(99, 0, bit_of(32), 1'b1, "partial_cell99");
    disp(100, 0, bit_of(32), 1'b0, "partial_cell100_space");
    disp(100, 0, bit_of(65), 1'b1, "partial_cell100_kept");
    disp(0, 0, bit_of(32), 1'b1, "partial_cell0");
    disp(94, 1, bit_of(66), 1'b1, "simul_host_write");
    disp(2, 1, bit_of(65), 1'b1, "untouched_A");
    scan_rows(0, 2);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
